mem_fifo_ctrl: RTL and testbench
================================

Name: mem_fifo_ctrl

Overview:
- Sequencer that sits directly upstream of memory_unit, the 8x8 single-port store. It drives memory_unit's select/op/addr/data_in and consumes its data_out.
- Presents memory_unit to the datapath as an 8-entry FIFO with valid/ready handshakes on both sides.
- Owns the pointers, the occupancy count, one-access-per-cycle arbitration, and a one-entry output register.

Parameters:
- DATA_W, 8, data width; must equal memory_unit data width.
- ADDR_W, 3, memory address width.
- DEPTH, 8, entries in memory; fixed at 2**ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  upstream has a word.
- in_ready  out  1  word accepted this cycle when in_valid && in_ready.
- in_data  in  DATA_W  write word.
- out_valid  out  1  out_data holds the FIFO head.
- out_ready  in  1  downstream takes the head this cycle.
- out_data  out  DATA_W  head word, registered.
- level  out  ADDR_W+1  words held: memory + in-flight read + output register, range 0..DEPTH+1.
- mem_select  out  1  to memory_unit.select.
- mem_op  out  1  to memory_unit.op; 1 = write, 0 = read.
- mem_addr  out  ADDR_W  to memory_unit.addr.
- mem_wdata  out  DATA_W  to memory_unit.data_in.
- mem_rdata  in  DATA_W  from memory_unit.data_out. Valid in the cycle after a read select; memory_unit updates it on the clock edge.

Behaviour:
- Reset (async, rst_n=0) values:
  - wr_ptr, rd_ptr, mem_cnt, rd_pend, out_valid, level all 0.
  - out_data 0.
  - mem_select/mem_op/mem_addr/mem_wdata all 0.
- State:
  - wr_ptr, rd_ptr: ADDR_W bits, wrap 7->0 naturally.
  - mem_cnt: 0..8, words resident in memory.
  - rd_pend: a read was issued last cycle.
  - out_valid/out_data: output register.
- Per-cycle arbitration, combinational from the current state; at most one memory access per cycle:
  - do_rd = mem_cnt!=0 && !rd_pend && (!out_valid || out_ready). Read has priority.
  - in_ready = !do_rd && mem_cnt!=DEPTH.
  - do_wr = in_valid && in_ready.
- Memory drive:
  - do_rd: select=1, op=0, addr=rd_ptr, wdata=0.
  - do_wr: select=1, op=1, addr=wr_ptr, wdata=in_data.
  - Otherwise: select=0, op=0, addr=0, wdata=0.
- Updates on the clock edge:
  - do_rd: rd_ptr+1, mem_cnt-1, rd_pend<=1.
  - Otherwise rd_pend<=0.
  - do_wr: wr_ptr+1, mem_cnt+1.
  - do_rd and do_wr are mutually exclusive by construction.
- Output register, in priority order:
  - rd_pend: out_data<=mem_rdata, out_valid<=1.
  - else out_valid && out_ready: out_valid<=0, out_data holds.
- Invariant: when rd_pend is set, the output register is empty or is being emptied that cycle, so no read data is ever dropped. Assert that !(rd_pend && out_valid && !out_ready) never occurs.
- Latency: a word written into an empty FIFO appears on out_valid 3 cycles after acceptance:
  - write at edge 0,
  - read issued in cycle 1,
  - captured at edge 2,
  - visible in cycle 2-3 window; first sampled at edge 3.
- Throughput: writes up to 1 per cycle. Reads at most 1 per 2 cycles, because rd_pend blocks back-to-back reads. Writes fill the idle cycles.
- level update: +1 on do_wr, -1 on (out_valid && out_ready), otherwise unchanged.
- Boundaries:
  - mem_cnt==DEPTH: in_ready=0, even if out_ready is asserted.
  - Empty (level==0): out_valid=0, memory idle.
  - in_valid held with in_ready=0: data is not sampled and upstream must hold it.
  - Reset mid-read: the pending read is discarded, the output register is cleared, and memory contents are don't-care.

Decomposition:
- Package mem_pkg: DATA_W, ADDR_W, DEPTH constants; MEM_OP_READ=1'b0, MEM_OP_WRITE=1'b1.
- No sub-module. A top-level mem_fifo_top instantiates mem_fifo_ctrl plus memory_unit for the bench.

Test Plan:
- Reset, then idle 4 cycles -> in_ready=1, out_valid=0, level=0, mem_select=0 every cycle.
- Single write 8'h49 with out_ready=1 -> mem_select=1/op=1/addr=0 in the accept cycle; read addr=0 next cycle; out_data=8'h49, out_valid=1 two edges after the read; level 1 -> 0 on take.
- Out_ready=0, write 9 words 8'h01..8'h09 -> the 9th is accepted only after the output register fills (level=9), then in_ready=0. Release out_ready -> outputs 01..09 in order, each exactly once.
- Wrap: stream 20 words with out_ready=1 -> output order matches input, wr_ptr/rd_ptr wrap 7->0 with no loss, level never exceeds 9.
- Simultaneous in_valid=1 on a read-issue cycle -> in_ready=0 that cycle, the word is accepted the following cycle, and no memory access conflicts occur (one select per cycle).
- rst_n pulsed low mid-stream with rd_pend=1 -> all outputs immediately at reset values; after release, level=0 and no stale out_valid.

Source files
------------

// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared constants for the memory_unit store and its FIFO sequencer.
//   DATA_W       : word width of memory_unit
//   ADDR_W       : address width of memory_unit
//   DEPTH        : number of words in memory_unit (2**ADDR_W)
//   MEM_OP_READ  : memory_unit.op encoding for a read
//   MEM_OP_WRITE : memory_unit.op encoding for a write
// -----------------------------------------------------------------------------
package mem_pkg;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 3;
   localparam int DEPTH  = 1 << ADDR_W;

   localparam logic MEM_OP_READ  = 1'b0;
   localparam logic MEM_OP_WRITE = 1'b1;

endpackage : mem_pkg

// File: rtl/mem_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// mem_fifo_ctrl
// Presents the single-port memory_unit as an 8-entry FIFO with valid/ready
// handshakes on both sides. Owns the read/write pointers, the memory occupancy
// count, one-access-per-cycle arbitration (reads win) and a one-entry output
// register that captures memory_unit read data.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   upstream offers in_data
//   in_ready   out  in_data is accepted this cycle when in_valid is also high
//   in_data    in   word to enqueue
//   out_valid  out  out_data holds the FIFO head
//   out_ready  in   downstream takes the head this cycle
//   out_data   out  registered FIFO head
//   level      out  words held: memory + in-flight read + output register
//   mem_select out  memory_unit.select
//   mem_op     out  memory_unit.op (1 = write, 0 = read)
//   mem_addr   out  memory_unit.addr
//   mem_wdata  out  memory_unit.data_in
//   mem_rdata  in   memory_unit.data_out, valid the cycle after a read select
// -----------------------------------------------------------------------------
module mem_fifo_ctrl
   import mem_pkg::*;
#(
   parameter int DATA_W_P = mem_pkg::DATA_W,
   parameter int ADDR_W_P = mem_pkg::ADDR_W,
   parameter int DEPTH_P  = 1 << ADDR_W_P
) (
   input  logic                clk,
   input  logic                rst_n,
   // upstream write side
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DATA_W_P-1:0] in_data,
   // downstream read side
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_W_P-1:0] out_data,
   output logic [ADDR_W_P:0]   level,
   // memory_unit interface
   output logic                mem_select,
   output logic                mem_op,
   output logic [ADDR_W_P-1:0] mem_addr,
   output logic [DATA_W_P-1:0] mem_wdata,
   input  logic [DATA_W_P-1:0] mem_rdata
);

   localparam logic [ADDR_W_P:0]   CNT_FULL = (ADDR_W_P+1)'(DEPTH_P);
   localparam logic [ADDR_W_P:0]   CNT_ONE  = (ADDR_W_P+1)'(1);
   localparam logic [ADDR_W_P-1:0] PTR_ONE  = ADDR_W_P'(1);

   logic [ADDR_W_P-1:0] wr_ptr;
   logic [ADDR_W_P-1:0] rd_ptr;
   logic [ADDR_W_P:0]   mem_cnt;
   logic                rd_pend;

   logic                do_rd;
   logic                do_wr;
   logic                take;

   assign take = out_valid && out_ready;

   // ---------------------------------------------------------------------------
   // Arbitration and memory drive.
   // A read is issued only when the output register will be free by the time
   // the data returns, and never back-to-back, so the captured word always has
   // somewhere to land. Writes use every cycle the read path leaves idle.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of this block gets a default before any branch, so
      // no path leaves a signal unassigned and no latch is inferred.
      do_rd      = 1'b0;
      do_wr      = 1'b0;
      in_ready   = 1'b0;
      mem_select = 1'b0;
      mem_op     = MEM_OP_READ;
      mem_addr   = '0;
      mem_wdata  = '0;

      // Held off while rst_n is low so the memory port is idle and nothing is
      // accepted during reset, even if upstream keeps in_valid asserted.
      if (rst_n) begin
         do_rd    = (mem_cnt != '0) && !rd_pend && (!out_valid || out_ready);
         in_ready = !do_rd && (mem_cnt != CNT_FULL);
         do_wr    = in_valid && in_ready;
      end

      if (do_rd) begin
         mem_select = 1'b1;
         mem_op     = MEM_OP_READ;
         mem_addr   = rd_ptr;
      end else if (do_wr) begin
         mem_select = 1'b1;
         mem_op     = MEM_OP_WRITE;
         mem_addr   = wr_ptr;
         mem_wdata  = in_data;
      end
   end

   // ---------------------------------------------------------------------------
   // Pointers, occupancy and read-pending flag.
   // do_rd and do_wr never coincide, so mem_cnt moves by at most one.
   // Pointers are ADDR_W bits wide and wrap 7 -> 0 on their own.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge values regardless of statement order.
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         mem_cnt <= '0;
         rd_pend <= 1'b0;
      end else begin
         rd_pend <= do_rd;
         if (do_rd) begin
            rd_ptr  <= rd_ptr + PTR_ONE;
            mem_cnt <= mem_cnt - CNT_ONE;
         end else if (do_wr) begin
            wr_ptr  <= wr_ptr + PTR_ONE;
            mem_cnt <= mem_cnt + CNT_ONE;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Output register. Returning read data wins over a take: when both happen
   // the old head leaves and the new word replaces it in the same edge.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (rd_pend) begin
         out_valid <= 1'b1;
         out_data  <= mem_rdata;
      end else if (take) begin
         out_valid <= 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // Level counts every word the FIFO owns, including one in flight from
   // memory. Range 0..DEPTH+1.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level <= '0;
      end else begin
         unique case ({do_wr, take})
            2'b10:   level <= level + CNT_ONE;
            2'b01:   level <= level - CNT_ONE;
            default: level <= level;
         endcase
      end
   end

   // Read data must never arrive while the output register is held full.
   a_no_drop : assert property (@(posedge clk) disable iff (!rst_n)
      !(rd_pend && out_valid && !out_ready));

endmodule : mem_fifo_ctrl

// File: tb/tb_mem_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_fifo_ctrl
// Self-checking bench for mem_fifo_ctrl. A behavioural 8x8 store stands in for
// memory_unit. Expected values come from a queue-based FIFO model and from a
// hand-derived vector table; a scoreboard checks that words leave in order.
// -----------------------------------------------------------------------------
module tb_mem_fifo_ctrl;
   import mem_pkg::*;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [DATA_W-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W:0]  level;
   logic             mem_select;
   logic             mem_op;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata = '0;

   always #5 clk = ~clk;

   mem_fifo_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .level      (level),
      .mem_select (mem_select),
      .mem_op     (mem_op),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   // memory_unit stand-in: synchronous write, registered read data
   logic [DATA_W-1:0] mem_arr [DEPTH];
   initial for (int i = 0; i < DEPTH; i++) mem_arr[i] = '0;
   always @(posedge clk) begin
      if (mem_select) begin
         if (mem_op) mem_arr[mem_addr] <= mem_wdata;
         else        mem_rdata        <= mem_arr[mem_addr];
      end
   end

   // ---------------------------------------------------------------- checking
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------- model
   // FIFO contents held as queues: words in memory, one word in flight from a
   // read, and the output register. Addresses are running counts modulo DEPTH.
   logic [DATA_W-1:0] mq[$];
   bit                m_pend;
   logic [DATA_W-1:0] m_pdata;
   bit                m_ov;
   logic [DATA_W-1:0] m_od;
   int                m_wr, m_rd;

   // per-cycle decisions latched by compare_model, applied by advance
   bit                c_rd, c_wr, c_ordy;
   logic [DATA_W-1:0] c_id;

   // scoreboard of DUT handshakes
   logic [DATA_W-1:0] sb[$];
   logic [DATA_W-1:0] taken_q[$];
   bit                dut_acc;
   int                max_level;

   task automatic model_reset();
      mq.delete();
      sb.delete();
      taken_q.delete();
      m_pend = 0; m_pdata = '0; m_ov = 0; m_od = '0;
      m_wr = 0; m_rd = 0;
   endtask

   task automatic drive(input bit iv, input logic [DATA_W-1:0] id, input bit ordy);
      @(negedge clk);
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      #1;
   endtask

   task automatic compare_model();
      bit e_ir;
      int lvl;
      c_ordy = out_ready;
      c_id   = in_data;
      c_rd   = (mq.size() != 0) && !m_pend && (!m_ov || c_ordy);
      e_ir   = !c_rd && (mq.size() != DEPTH);
      c_wr   = in_valid && e_ir;
      lvl    = mq.size() + int'(m_pend) + int'(m_ov);
      check("in_ready", in_ready, e_ir);
      check("out_valid", out_valid, m_ov);
      if (m_ov) check("out_data", out_data, m_od);
      check("level", level, lvl);
      check("mem_select", mem_select, c_rd || c_wr);
      if (c_rd) begin
         check("mem_op", mem_op, MEM_OP_READ);
         check("mem_addr", mem_addr, m_rd % DEPTH);
      end else if (c_wr) begin
         check("mem_op", mem_op, MEM_OP_WRITE);
         check("mem_addr", mem_addr, m_wr % DEPTH);
         check("mem_wdata", mem_wdata, c_id);
      end else begin
         check("mem_idle", {mem_op, 5'(mem_addr), mem_wdata}, 0);
      end
      if (level > max_level) max_level = level;
      // scoreboard driven purely by the DUT's own handshakes
      if (out_valid && out_ready) begin
         check("sb_nonempty", sb.size() != 0, 1);
         if (sb.size() != 0) check("sb_order", out_data, sb.pop_front());
         taken_q.push_back(out_data);
      end
      dut_acc = in_valid && in_ready;
      if (dut_acc) sb.push_back(in_data);
   endtask

   task automatic advance();
      @(posedge clk);
      if (m_pend) begin
         m_ov = 1; m_od = m_pdata;
      end else if (m_ov && c_ordy) begin
         m_ov = 0;
      end
      m_pend = c_rd;
      if (c_rd) begin
         m_pdata = mq.pop_front();
         m_rd++;
      end
      if (c_wr) begin
         mq.push_back(c_id);
         m_wr++;
      end
   endtask

   task automatic step(input bit iv, input logic [DATA_W-1:0] id, input bit ordy);
      drive(iv, id, ordy);
      compare_model();
      advance();
   endtask

   task automatic push_word(input logic [DATA_W-1:0] d, input bit ordy);
      bit done;
      done = 0;
      for (int k = 0; k < 40 && !done; k++) begin
         drive(1'b1, d, ordy);
         compare_model();
         done = dut_acc;
         advance();
      end
      check("push_accepted", done, 1);
   endtask

   task automatic drain(input int n);
      for (int k = 0; k < 200 && taken_q.size() < n; k++) step(1'b0, '0, 1'b1);
      check("drain_count", taken_q.size(), n);
   endtask

   // ------------------------------------------------------------ vector table
   typedef struct {
      bit                iv;
      logic [DATA_W-1:0] id;
      bit                ordy;
      bit                ir;
      bit                ov;
      logic [DATA_W-1:0] od;
      int                lvl;
      bit                sel;
      bit                op;
      int                addr;
      logic [DATA_W-1:0] wd;
   } vec_t;

   vec_t tv[$];

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      max_level = 0;
      model_reset();

      // reset state while rst_n is low, with upstream offering a word
      #12;
      in_valid = 1'b1;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_level", level, 0);
      check("rst_out_data", out_data, 0);
      check("rst_mem", {mem_select, mem_op, 5'(mem_addr), mem_wdata}, 0);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b1;

      // iv id ordy | ir ov od lvl sel op addr wd
      for (int i = 0; i < 4; i++) tv.push_back('{0, 8'h00, 1, 1, 0, 8'h00, 0, 0, 0, 0, 8'h00});
      tv.push_back('{1, 8'h49, 1, 1, 0, 8'h00, 0, 1, 1, 0, 8'h49});  // accept 49
      tv.push_back('{0, 8'h00, 1, 0, 0, 8'h00, 1, 1, 0, 0, 8'h00});  // read addr 0
      tv.push_back('{0, 8'h00, 1, 1, 0, 8'h00, 1, 0, 0, 0, 8'h00});  // in flight
      tv.push_back('{0, 8'h00, 1, 1, 1, 8'h49, 1, 0, 0, 0, 8'h00});  // head, taken
      tv.push_back('{0, 8'h00, 1, 1, 0, 8'h00, 0, 0, 0, 0, 8'h00});  // empty
      tv.push_back('{1, 8'hA1, 1, 1, 0, 8'h00, 0, 1, 1, 1, 8'hA1});  // accept A1
      tv.push_back('{1, 8'hB2, 1, 0, 0, 8'h00, 1, 1, 0, 1, 8'h00});  // read wins
      tv.push_back('{1, 8'hB2, 1, 1, 0, 8'h00, 1, 1, 1, 2, 8'hB2});  // B2 next cycle
      tv.push_back('{0, 8'h00, 1, 0, 1, 8'hA1, 2, 1, 0, 2, 8'h00});  // take A1 + read
      tv.push_back('{0, 8'h00, 1, 1, 0, 8'h00, 1, 0, 0, 0, 8'h00});
      tv.push_back('{0, 8'h00, 1, 1, 1, 8'hB2, 1, 0, 0, 0, 8'h00});
      tv.push_back('{0, 8'h00, 1, 1, 0, 8'h00, 0, 0, 0, 0, 8'h00});

      foreach (tv[i]) begin
         drive(tv[i].iv, tv[i].id, tv[i].ordy);
         check($sformatf("tv%0d_in_ready", i), in_ready, tv[i].ir);
         check($sformatf("tv%0d_out_valid", i), out_valid, tv[i].ov);
         if (tv[i].ov) check($sformatf("tv%0d_out_data", i), out_data, tv[i].od);
         check($sformatf("tv%0d_level", i), level, tv[i].lvl);
         check($sformatf("tv%0d_mem_select", i), mem_select, tv[i].sel);
         if (tv[i].sel) begin
            check($sformatf("tv%0d_mem_op", i), mem_op, tv[i].op);
            check($sformatf("tv%0d_mem_addr", i), mem_addr, tv[i].addr);
            if (tv[i].op) check($sformatf("tv%0d_mem_wdata", i), mem_wdata, tv[i].wd);
         end
         compare_model();
         advance();
      end

      // fill: 9 words with downstream stalled
      taken_q.delete();
      for (int w = 1; w <= 9; w++) push_word(8'(w), 1'b0);
      drive(1'b1, 8'h0A, 1'b0);
      check("full_level", level, 9);
      check("full_in_ready", in_ready, 0);
      compare_model();
      advance();
      drive(1'b1, 8'h0A, 1'b1);
      check("full_in_ready_ordy", in_ready, 0);
      compare_model();
      advance();
      drain(9);
      for (int i = 0; i < 9 && i < taken_q.size(); i++)
         check($sformatf("full_order%0d", i), taken_q[i], i + 1);

      // wrap: 20 words streamed with downstream ready
      taken_q.delete();
      max_level = 0;
      for (int w = 0; w < 20; w++) push_word(8'h10 + 8'(w), 1'b1);
      drain(20);
      for (int i = 0; i < 20 && i < taken_q.size(); i++)
         check($sformatf("wrap_order%0d", i), taken_q[i], 8'h10 + i);
      check("wrap_max_level_le9", max_level <= 9, 1);

      // randomized traffic
      for (int k = 0; k < 800; k++) begin
         step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0);
      end

      // reset while a read is in flight
      step(1'b1, 8'h55, 1'b0);
      step(1'b1, 8'h66, 1'b0);   // read issued here, rd_pend set after the edge
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_out_data", out_data, 0);
      check("midrst_level", level, 0);
      check("midrst_mem", {mem_select, mem_op, 5'(mem_addr), mem_wdata}, 0);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b1;
      model_reset();
      for (int k = 0; k < 4; k++) step(1'b0, '0, 1'b1);
      check("post_rst_level", level, 0);
      check("post_rst_out_valid", out_valid, 0);

      // short burst after reset to show recovery
      taken_q.delete();
      for (int w = 0; w < 3; w++) push_word(8'hC0 + 8'(w), 1'b1);
      drain(3);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // absolute time limit
   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule : tb_mem_fifo_ctrl
